// File: rtl/executing_muldiv.sv
// Execute stage: forwarding muxes, single-cycle ALU with registered outputs, and a
// multi-cycle MUL/DIV unit that owns the HI/LO registers and stalls upstream while busy.
module executing_muldiv #(
    parameter int WIDTH      = 32,
    parameter int REG_BITS   = 5,
    parameter int MUL_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inValid,
    input  logic [4:0]          aluOpInput,
    input  logic                aluSrcInput,
    input  logic                regDstInput,
    input  logic                memToRegInput,
    input  logic                regWriteInput,
    input  logic                memWriteInput,
    input  logic                memReadInput,
    input  logic [WIDTH-1:0]    immediateExtendedInput,
    input  logic [4:0]          shamtInput,
    input  logic [REG_BITS-1:0] addressRtInput,
    input  logic [REG_BITS-1:0] addressRdInput,
    input  logic [WIDTH-1:0]    dataRsInput,
    input  logic [WIDTH-1:0]    dataRtInput,
    input  logic [1:0]          forwardingMux0Input,
    input  logic [1:0]          forwardingMux1Input,
    input  logic [WIDTH-1:0]    regWriteDataWbInput,
    input  logic [WIDTH-1:0]    aluResultMemInput,
    output logic                busyOutput,
    output logic                outValid,
    output logic                memToRegOutput,
    output logic                regWriteOutput,
    output logic                memWriteOutput,
    output logic                memReadOutput,
    output logic [WIDTH-1:0]    aluResultOutput,
    output logic [WIDTH-1:0]    memWriteDataOutput,
    output logic [REG_BITS-1:0] regWriteRegisterOutput,
    output logic                aluResultZeroOutput,
    output logic                divByZeroOutput
);

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB  = 5'd1,  OP_AND   = 5'd2,  OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4,  OP_NOR  = 5'd5,  OP_SLT   = 5'd6,  OP_SLTU = 5'd7;
    localparam logic [4:0] OP_SLL = 5'd8,  OP_SRL  = 5'd9,  OP_SRA   = 5'd10, OP_MULT = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12, OP_DIV = 5'd13, OP_DIVU = 5'd14;
    localparam logic [4:0] OP_MFHI = 5'd16, OP_MFLO = 5'd17, OP_MTHI = 5'd18, OP_MTLO = 5'd19;
    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t               state, state_nx;
    logic                 accept, is_mul, is_div, is_mt, single, op_signed;
    logic                 mul_done, div_done;
    logic [WIDTH-1:0]     op_a, op_b, st_data, result, abs_a, abs_b;
    logic [WIDTH-1:0]     hi, lo;
    logic [31:0]          sh_amt;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     opa_q, opb_q, quo, rem, dvs;
    logic                 sgn_q, div_zero_q;
    logic [2*WIDTH-1:0]   ext_a, ext_b, prod;
    logic [WIDTH:0]       shifted, diff;
    logic [WIDTH-1:0]     quo_n, rem_n, q_fin, r_fin;

    assign busyOutput = (state != IDLE);
    assign accept     = inValid && !busyOutput;
    assign is_mul     = (aluOpInput == OP_MULT) || (aluOpInput == OP_MULTU);
    assign is_div     = (aluOpInput == OP_DIV)  || (aluOpInput == OP_DIVU);
    assign is_mt      = (aluOpInput == OP_MTHI) || (aluOpInput == OP_MTLO);
    assign single     = !(is_mul || is_div || is_mt);
    assign op_signed  = (aluOpInput == OP_MULT) || (aluOpInput == OP_DIV);

    // Forwarding: codes 0 and 3 both fall back to register-file data.
    always_comb begin
        op_a = dataRsInput;
        unique case (forwardingMux0Input)
            2'd1:    op_a = regWriteDataWbInput;
            2'd2:    op_a = aluResultMemInput;
            default: op_a = dataRsInput;
        endcase
        st_data = dataRtInput;
        unique case (forwardingMux1Input)
            2'd1:    st_data = regWriteDataWbInput;
            2'd2:    st_data = aluResultMemInput;
            default: st_data = dataRtInput;
        endcase
        op_b = aluSrcInput ? immediateExtendedInput : st_data;
    end

    assign sh_amt = 32'(shamtInput) % WIDTH;

    always_comb begin
        result = op_a + op_b;
        case (aluOpInput)
            OP_SUB:  result = op_a - op_b;
            OP_AND:  result = op_a & op_b;
            OP_OR:   result = op_a | op_b;
            OP_XOR:  result = op_a ^ op_b;
            OP_NOR:  result = ~(op_a | op_b);
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            OP_SLL:  result = op_b << sh_amt;
            OP_SRL:  result = op_b >> sh_amt;
            OP_SRA:  result = $signed(op_b) >>> sh_amt;
            OP_MFHI: result = hi;
            OP_MFLO: result = lo;
            default: result = op_a + op_b;
        endcase
    end

    // Multiplier works on the latched operands; result taken on the last MUL cycle.
    assign ext_a = sgn_q ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
    assign ext_b = sgn_q ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
    assign prod  = ext_a * ext_b;

    // Divider runs on magnitudes; signs are re-applied when the result is written.
    assign abs_a   = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign abs_b   = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign rem_n   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_n   = {quo[WIDTH-2:0], ~diff[WIDTH]};
    assign q_fin   = (sgn_q && (opa_q[WIDTH-1] ^ opb_q[WIDTH-1])) ? -quo_n : quo_n;
    assign r_fin   = (sgn_q && opa_q[WIDTH-1]) ? -rem_n : rem_n;

    assign mul_done = (cnt == CW'(MUL_CYCLES - 1));
    assign div_done = div_zero_q || (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && is_mul)      state_nx = MUL;
                  else if (accept && is_div) state_nx = DIV;
            MUL:  if (mul_done) state_nx = IDLE;
            DIV:  if (div_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)               cnt <= '0;
        else if (accept)         cnt <= '0;
        else if (state != IDLE)  cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept && (is_mul || is_div)) begin
            opa_q      <= op_a;
            opb_q      <= op_b;
            sgn_q      <= op_signed;
            quo        <= abs_a;
            dvs        <= abs_b;
            rem        <= '0;
            div_zero_q <= (op_b == '0);
        end else if (state == DIV) begin
            quo <= quo_n;
            rem <= rem_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (accept && aluOpInput == OP_MTHI) begin
            hi <= op_a;
        end else if (accept && aluOpInput == OP_MTLO) begin
            lo <= op_a;
        end else if (state == MUL && mul_done) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
        end else if (state == DIV && div_done) begin
            hi <= div_zero_q ? opa_q : r_fin;
            lo <= div_zero_q ? '1    : q_fin;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outValid               <= 1'b0;
            memToRegOutput         <= 1'b0;
            regWriteOutput         <= 1'b0;
            memWriteOutput         <= 1'b0;
            memReadOutput          <= 1'b0;
            aluResultOutput        <= '0;
            memWriteDataOutput     <= '0;
            regWriteRegisterOutput <= '0;
            aluResultZeroOutput    <= 1'b0;
            divByZeroOutput        <= 1'b0;
        end else begin
            divByZeroOutput <= (state == DIV) && div_zero_q;
            if (accept && single) begin
                outValid               <= 1'b1;
                memToRegOutput         <= memToRegInput;
                regWriteOutput         <= regWriteInput;
                memWriteOutput         <= memWriteInput;
                memReadOutput          <= memReadInput;
                aluResultOutput        <= result;
                memWriteDataOutput     <= st_data;
                regWriteRegisterOutput <= regDstInput ? addressRdInput : addressRtInput;
                aluResultZeroOutput    <= (result == '0);
            end else begin
                // Data outputs hold; only the qualifiers drop.
                outValid       <= 1'b0;
                regWriteOutput <= 1'b0;
                memWriteOutput <= 1'b0;
                memReadOutput  <= 1'b0;
            end
        end
    end

endmodule
